// File: rtl/gcd_lcm_pkg.sv
// Shared types and defaults for the GCD/LCM coprocessor.
package gcd_lcm_pkg;

  localparam int COPRO_WIDTH = 32;

  typedef enum logic {
    OP_GCD = 1'b0,
    OP_LCM = 1'b1
  } copro_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } copro_state_e;

endpackage

// File: rtl/gcd_lcm_step.sv
// One combinational GCD/LCM iteration: subtractive GCD step or additive LCM
// multiple step, plus equality and carry-out flags for the controlling FSM.
module gcd_lcm_step
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = COPRO_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] sa_i,
  input  logic [WIDTH-1:0] sb_i,
  input  copro_op_e        op_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             eq_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // branches below leaves a signal unassigned and infers a latch.
    x_o     = x_i;
    y_o     = y_i;
    carry_o = 1'b0;
    sum     = '0;
    eq_o    = (x_i == y_i);
    if (op_i == OP_GCD) begin
      if (x_i > y_i) x_o = x_i - y_i;
      else           y_o = y_i - x_i;
    end else if (x_i < y_i) begin
      sum     = {1'b0, x_i} + {1'b0, sa_i};
      x_o     = sum[WIDTH-1:0];
      carry_o = sum[WIDTH];
    end else begin
      sum     = {1'b0, y_i} + {1'b0, sb_i};
      y_o     = sum[WIDTH-1:0];
      carry_o = sum[WIDTH];
    end
  end

endmodule

// File: rtl/gcd_lcm_coproc.sv
// Iterative GCD/LCM coprocessor: accepts a start pulse from the core, stalls
// it via busy while stepping, and pulses done with the registered result.
module gcd_lcm_coproc
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = COPRO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  copro_state_e     state_q;
  copro_op_e        op_q;
  logic [WIDTH-1:0] x_q, y_q, sa_q, sb_q;
  logic [WIDTH-1:0] x_d, y_d;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q, done_q;
  logic             eq, carry;

  gcd_lcm_step #(.WIDTH(WIDTH)) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .sa_i   (sa_q),
    .sb_i   (sb_q),
    .op_i   (op_q),
    .x_o    (x_d),
    .y_o    (y_d),
    .eq_o   (eq),
    .carry_o(carry)
  );

  // NOTE: all state here is sequential, so it is written with non-blocking
  // assignments; blocking ones would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_GCD;
      x_q        <= '0;
      y_q        <= '0;
      sa_q       <= '0;
      sb_q       <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q        <= src_a;
            y_q        <= src_b;
            sa_q       <= src_a;
            sb_q       <= src_b;
            op_q       <= copro_op_e'(op);
            overflow_q <= 1'b0;
            // A zero operand has a closed-form answer; skip the step loop.
            if (src_a == '0 || src_b == '0) begin
              result_q <= op ? '0 : (src_a | src_b);
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (eq) begin
            result_q <= x_q;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (op_q == OP_LCM && carry) begin
            overflow_q <= 1'b1;
            result_q   <= '0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Self-checking bench for gcd_lcm_coproc: directed corner cases plus random
// operations compared against a Euclid/quotient-based reference model.
module tb_gcd_lcm_coproc;

  localparam int W     = 32;
  localparam int LIMIT = 10000;

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, overflow;
  logic [W-1:0] result;

  int vectors     = 0;
  int miscompares = 0;

  gcd_lcm_coproc #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractive steps = sum of Euclid quotients, less the final equal compare.
  function automatic int gcd_iters(input longint unsigned a, input longint unsigned b);
    int n = 0;
    longint unsigned t;
    while (b != 0) begin
      n += int'(a / b);
      t = a % b;
      a = b;
      b = t;
    end
    return n - 1;
  endfunction

  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, output int lat, output logic [W-1:0] res,
                        output logic ovf, output bit busy_ok);
    lat     = -1;
    res     = '0;
    ovf     = 1'b0;
    busy_ok = 1'b1;
    @(negedge clk);
    check("idle_before_start", {62'd0, busy, done}, 64'd0);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      if (poke && k == 1) begin
        start = 1'b1; src_a = 32'd5; src_b = 32'd5; op = 1'b0;
      end
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        res = result;
        ovf = overflow;
        break;
      end
      @(posedge clk); #1 start = 1'b0;
    end
    start = 1'b0;
    if (lat < 0) begin
      check("timeout", 64'd1, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
    end
  endtask

  task automatic apply(input string tag, input logic o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit poke);
    int              lat, exp_lat;
    logic [W-1:0]    res, exp_res;
    logic            ovf, exp_ovf;
    bit              busy_ok;
    longint unsigned g, l;
    exp_ovf = 1'b0;
    if (a == 0 || b == 0) begin
      exp_res = o ? '0 : (a | b);
      exp_lat = 1;
    end else begin
      g = ref_gcd(a, b);
      if (o == 1'b0) begin
        exp_res = g[W-1:0];
        exp_lat = gcd_iters(a, b) + 2;
      end else begin
        l = (longint'(a) / g) * longint'(b);
        if (l > 64'h0000_0000_FFFF_FFFF) begin
          exp_ovf = 1'b1;
          exp_res = '0;
          exp_lat = -1;
        end else begin
          exp_res = l[W-1:0];
          exp_lat = int'(l / a) + int'(l / b);
        end
      end
    end
    run_op(o, a, b, poke, lat, res, ovf, busy_ok);
    if (lat >= 0) begin
      check({tag, "_result"}, res, exp_res);
      check({tag, "_overflow"}, ovf, exp_ovf);
      check({tag, "_busy"}, busy_ok, 1'b1);
      if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    end
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 0);
    check("reset_overflow", overflow, 1'b0);
    reset = 1'b0;

    apply("lcm_4_6", 1'b1, 32'd4, 32'd6, 1'b0);

    // Abandon GCD(12,18) with a one-cycle reset in cycle c+2.
    @(negedge clk);
    op = 1'b0; src_a = 32'd12; src_b = 32'd18; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_result", result, 0);
    saw_done = done;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);

    apply("gcd_12_18", 1'b0, 32'd12, 32'd18, 1'b0);
    apply("gcd_busy_start", 1'b0, 32'd12, 32'd18, 1'b1);
    apply("gcd_7_7_b2b", 1'b0, 32'd7, 32'd7, 1'b0);
    apply("gcd_0_9", 1'b0, 32'd0, 32'd9, 1'b0);
    apply("gcd_0_0", 1'b0, 32'd0, 32'd0, 1'b0);
    apply("lcm_7_0", 1'b1, 32'd7, 32'd0, 1'b0);
    apply("lcm_ovf", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    check("ovf_single_done", done, 1'b0);
    check("ovf_held", overflow, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic         o;
      logic [W-1:0] a, b;
      o = 1'($urandom_range(0, 1));
      if (o == 1'b0) begin
        a = $urandom_range(1, 4095);
        b = $urandom_range(1, 4095);
      end else begin
        a = $urandom_range(1, 200);
        b = $urandom_range(1, 200);
      end
      if ($urandom_range(0, 9) == 0) a = '0;
      apply(o ? "rand_lcm" : "rand_gcd", o, a, b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gcd_lcm_coproc.md
Name: gcd_lcm_coproc

Overview:
Iterative GCD/LCM coprocessor that sits directly downstream of the single-cycle core's controller/datapath.
- Consumes the controller's Start pulse, a function select, and two register-file operands (rs1, rs2).
- Returns a result for writeback plus busy/done handshake signals; the core stalls PC on busy.
- GCD and LCM share one compare/step datapath. GCD uses subtraction; LCM uses additive multiple-stepping.

Parameters:
WIDTH, 32, operand/result width in bits

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request from controller; ignored unless state is IDLE
op  input  1  0 = GCD, 1 = LCM; sampled with start
src_a  input  WIDTH  operand A (unsigned); sampled with start
src_b  input  WIDTH  operand B (unsigned); sampled with start
busy  output  1  high whenever state is not IDLE (core stall request)
done  output  1  one-cycle pulse; result/overflow valid in that cycle
result  output  WIDTH  GCD/LCM value; held stable until the next accepted start
overflow  output  1  LCM exceeded WIDTH bits; held with result

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, busy=0, done=0, result=0, overflow=0, x=y=0, sa=sb=0, op_q=0.
- Reset mid-operation: the computation is abandoned and no done pulse is issued.
- Internal registers: x, y (WIDTH), sa, sb (step values, WIDTH), op_q.
- IDLE:
  - On start=1: x<=src_a, y<=src_b, sa<=src_a, sb<=src_b, op_q<=op, overflow<=0.
  - If src_a==0 or src_b==0, go straight to DONE with result <= (op ? 0 : src_a|src_b). This gives gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0, lcm(x,0)=0.
  - Otherwise go to RUN.
- RUN, one step per cycle:
  - If x==y: result<=x, go to DONE.
  - GCD, x!=y: if x>y then x<=x-y, else y<=y-x.
  - LCM, x!=y: if x<y then x<=x+sa, else y<=y+sb.
  - LCM carry-out of the WIDTH-bit add: overflow<=1, result<=0, go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Busy and start:
  - busy is combinational from state: 1 in RUN and DONE.
  - start while busy is ignored and has no side effects.
  - start in the cycle after DONE (state IDLE) is accepted normally.
- Latency: start accepted in cycle c; N = number of unequal RUN iterations.
  - done is high in cycle c+N+2.
  - Zero-operand case: done is high in cycle c+1.
  - Equal operands: N=0, done at c+2, result=operand.
- Bounds: GCD iterations ≤ max(a,b), so the worst case is about 2^WIDTH cycles. No timeout; software owns this bound.
- Arithmetic: all unsigned, WIDTH-bit. Subtraction never underflows because of the compare guard.
- result and overflow change only on a DONE transition or on reset.

Decomposition:
- Package gcd_lcm_pkg:
  - enum copro_op_e {OP_GCD=1'b0, OP_LCM=1'b1}
  - enum copro_state_e {S_IDLE, S_RUN, S_DONE} (2 bits)
  - default width constant COPRO_WIDTH=32
- Optional sub-module gcd_lcm_step: purely combinational. Takes x, y, sa, sb, op; returns next x, next y, eq, carry. The FSM and registers stay in gcd_lcm_coproc.

Test Plan:
- Reset mid-operation: start op=GCD, a=12, b=18, assert reset at c+2 for 1 cycle -> busy=0, result=0 next cycle, no done pulse. Then start GCD a=12, b=18 -> done at c+4, result=6, overflow=0.
- LCM basic: start op=LCM, a=4, b=6 -> N=3, done at c+5, result=12, busy high c+1..c+5.
- Zero operands: GCD(0,9) -> done at c+1, result=9. GCD(0,0) -> result=0. LCM(7,0) -> result=0, overflow=0.
- LCM overflow: LCM(0xFFFFFFFF, 0xFFFFFFFE) -> overflow=1, result=0, single done pulse.
- Start during busy: second start (a=5, b=5) while computing GCD(12,18) -> ignored; result=6 at c+4.
- Back-to-back: start in the cycle after done with GCD(7,7) -> done 2 cycles later, result=7.
